// File: rtl/div_unit.sv
// rtl/div_unit.sv - 32-bit signed/unsigned restoring divider, {remainder, quotient} result
// Optional build macro: DIV_EARLY_OUT_EN (skip iterations when |dividend| < |divisor|)
module div_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        signed_div_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   input  logic        start_i,
   input  logic        annul_i,
   output logic [63:0] result_o,
   output logic        ready_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DBZ  = 2'd1;
   localparam logic [1:0] S_ON   = 2'd2;
   localparam logic [1:0] S_END  = 2'd3;

   logic [1:0]  r_state;
   logic [5:0]  r_cnt;
   logic [31:0] r_rem;      // partial remainder magnitude
   logic [31:0] r_quo;      // dividend bits shift out the top, quotient bits shift in
   logic [31:0] r_dvs;      // divisor magnitude
   logic        r_neg_q;
   logic        r_neg_r;
   logic [63:0] r_final;    // result presented while END holds

   logic [31:0] w_mag1;
   logic [31:0] w_mag2;
   logic [32:0] w_shift;
   logic [32:0] w_diff;
   logic [31:0] w_q_fix;
   logic [31:0] w_r_fix;
   logic        w_early;

   // Operand magnitudes; 0x80000000 negates to itself, which is 2^31 unsigned
   assign w_mag1 = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
   assign w_mag2 = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

   // One restoring step: bit 32 of the difference is the borrow
   assign w_shift = {r_rem, r_quo[31]};
   assign w_diff  = w_shift - {1'b0, r_dvs};

   assign w_q_fix = r_neg_q ? (~r_quo + 32'd1) : r_quo;
   assign w_r_fix = r_neg_r ? (~r_rem + 32'd1) : r_rem;

`ifdef DIV_EARLY_OUT_EN
   assign w_early = (w_mag1 < w_mag2);
`else
   assign w_early = 1'b0;
`endif

   // Divider state machine, datapath and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= 6'd0;
         r_rem    <= 32'd0;
         r_quo    <= 32'd0;
         r_dvs    <= 32'd0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_final  <= 64'd0;
         result_o <= 64'd0;
         ready_o  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               ready_o  <= 1'b0;
               result_o <= 64'd0;
               if (start_i) begin
                  r_rem   <= 32'd0;
                  r_quo   <= w_mag1;
                  r_dvs   <= w_mag2;
                  r_neg_q <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                  r_neg_r <= signed_div_i & opdata1_i[31];
                  r_cnt   <= 6'd0;
                  if (opdata2_i == 32'd0) begin
                     r_final <= 64'd0;
                     r_state <= S_DBZ;
                  end else if (w_early) begin
                     // quotient 0, remainder is the dividend itself (sign included)
                     r_final <= {opdata1_i, 32'h0};
                     r_state <= S_END;
                  end else begin
                     r_state <= S_ON;
                  end
               end
            end
            S_DBZ: begin
               r_state <= annul_i ? S_IDLE : S_END;
            end
            S_ON: begin
               if (annul_i) begin
                  r_state <= S_IDLE;
               end else if (r_cnt == 6'd32) begin
                  r_final  <= {w_r_fix, w_q_fix};
                  result_o <= {w_r_fix, w_q_fix};
                  ready_o  <= 1'b1;
                  r_state  <= S_END;
               end else begin
                  if (!w_diff[32]) begin
                     r_rem <= w_diff[31:0];
                     r_quo <= {r_quo[30:0], 1'b1};
                  end else begin
                     r_rem <= w_shift[31:0];
                     r_quo <= {r_quo[30:0], 1'b0};
                  end
                  r_cnt <= r_cnt + 6'd1;
               end
            end
            S_END: begin
               if (start_i) begin
                  ready_o  <= 1'b1;
                  result_o <= r_final;
               end else begin
                  ready_o  <= 1'b0;
                  result_o <= 64'd0;
                  r_state  <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard bench for div_unit with directed vectors
module tb_div_unit;

   logic        clk;
   logic        rst;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;

`ifdef DIV_EARLY_OUT_EN
   localparam int EL = 1;
`else
   localparam int EL = 33;
`endif

   typedef struct {
      logic [63:0] res;
      int          lat;
      int          e0;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic prev_ready = 1'b0;

   div_unit dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: each rising ready_o consumes one expected result
   always @(negedge clk) begin
      if (!rst) begin
         if (ready_o && !prev_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_ready: result=%h at cycle %0d, no divide pending", result_o, cyc);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (result_o !== e.res) begin
                  errors++;
                  $display("FAIL result: got %h expected %h", result_o, e.res);
               end
               checks++;
               if ((cyc - e.e0) != e.lat) begin
                  errors++;
                  $display("FAIL latency: got %0d expected %0d (result %h)", cyc - e.e0, e.lat, e.res);
               end
            end
         end
         if (!ready_o) begin
            checks++;
            if (result_o !== 64'd0) begin
               errors++;
               $display("FAIL result_zero_when_idle: got %h expected 0", result_o);
            end
         end
      end
      prev_ready = ready_o;
   end

   task automatic check_idle_out(input string name);
      checks++;
      if (ready_o !== 1'b0 || result_o !== 64'd0) begin
         errors++;
         $display("FAIL %s: ready=%b result=%h expected ready=0 result=0", name, ready_o, result_o);
      end
   endtask

   // Issue one divide, scramble inputs after capture, wait for ready, hold, then release
   task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic ann, input logic [63:0] res, input int lat);
      exp_t e;
      bit   seen;
      @(negedge clk);
      signed_div_i = sgn;
      opdata1_i    = a;
      opdata2_i    = b;
      annul_i      = ann;
      start_i      = 1'b1;
      @(posedge clk);
      #1;
      e.res = res;
      e.lat = lat;
      e.e0  = cyc;
      exp_q.push_back(e);
      annul_i      = 1'b0;
      opdata1_i    = $urandom;
      opdata2_i    = $urandom;
      signed_div_i = ~sgn;
      seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (ready_o) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL timeout: no ready for %h / %h", a, b);
      end else begin
         @(negedge clk);
         checks++;
         if (ready_o !== 1'b1 || result_o !== res) begin
            errors++;
            $display("FAIL hold: ready=%b result=%h expected ready=1 result=%h", ready_o, result_o, res);
         end
      end
      start_i = 1'b0;
      @(posedge clk);
      #1;
      check_idle_out("release");
   endtask

   initial begin
      rst          = 1'b1;
      start_i      = 1'b0;
      annul_i      = 1'b0;
      signed_div_i = 1'b0;
      opdata1_i    = 32'd0;
      opdata2_i    = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check_idle_out("reset_state");
      rst = 1'b0;

      do_div(1'b0, 32'd100,        32'd7,        1'b0, 64'h00000002_0000000E, 33);
      do_div(1'b1, 32'hFFFFFFF9,   32'd2,        1'b0, 64'hFFFFFFFF_FFFFFFFD, 33);
      do_div(1'b1, 32'h80000000,   32'hFFFFFFFF, 1'b0, 64'h00000000_80000000, 33);
      do_div(1'b0, 32'd5,          32'd9,        1'b0, 64'h00000005_00000000, EL);
      do_div(1'b0, 32'd1234,       32'd0,        1'b0, 64'h0, 2);
      do_div(1'b1, 32'hFFFFFFFB,   32'd0,        1'b0, 64'h0, 2);
      do_div(1'b0, 32'hFFFFFFFF,   32'h10,       1'b0, 64'h0000000F_0FFFFFFF, 33);
      do_div(1'b1, 32'd7,          32'hFFFFFFFE, 1'b0, 64'h00000001_FFFFFFFD, 33);
      do_div(1'b1, 32'hFFFFFFFB,   32'd9,        1'b0, 64'hFFFFFFFB_00000000, EL);
      do_div(1'b0, 32'h80000000,   32'hFFFFFFFF, 1'b0, 64'h80000000_00000000, EL);
      // start and annul together in IDLE: divide proceeds
      do_div(1'b1, 32'hFFFFFFF8,   32'hFFFFFFFD, 1'b1, 64'hFFFFFFFE_00000002, 33);

      // annul 10 cycles into a divide, then start 9/3 immediately
      @(negedge clk);
      signed_div_i = 1'b0;
      opdata1_i    = 32'd1000;
      opdata2_i    = 32'd3;
      start_i      = 1'b1;
      @(posedge clk);
      repeat (9) @(posedge clk);
      @(negedge clk);
      annul_i = 1'b1;
      @(posedge clk);
      #1;
      check_idle_out("after_annul");
      do_div(1'b0, 32'd9, 32'd3, 1'b0, 64'h00000000_00000003, 33);

      // reset 20 cycles into a divide, then 50/5
      @(negedge clk);
      signed_div_i = 1'b0;
      opdata1_i    = 32'd123;
      opdata2_i    = 32'd4;
      start_i      = 1'b1;
      @(posedge clk);
      repeat (19) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_idle_out("after_reset");
      rst = 1'b0;
      do_div(1'b0, 32'd50, 32'd5, 1'b0, 64'h00000000_0000000A, 33);

      repeat (5) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending: %0d expected results never appeared, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
